// File: rtl/dmem_ctrl.sv
// Data-memory access controller: turns one MEM-stage load/store into a single bus transaction.
// Optional watchdog compiled in with `define DMEM_TIMEOUT_EN (parameter TIMEOUT_CYCLES).
module dmem_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        REQ_VALID,
   input  logic        REQ_WE,
   input  logic [31:0] REQ_ADDR,
   input  logic [3:0]  REQ_WMASK,
   input  logic [31:0] REQ_WDATA,
   output logic        STALL,
   output logic        RSP_VALID,
   output logic [31:0] RSP_RDATA,
   output logic        TRAP_VALID,
   output logic [30:0] TRAP_MCAUSE,
   output logic        M_VALID,
   input  logic        M_READY,
   output logic        M_WE,
   output logic [31:0] M_ADDR,
   output logic [3:0]  M_WSTRB,
   output logic [31:0] M_WDATA,
   input  logic        M_RVALID,
   input  logic [31:0] M_RDATA,
   input  logic        M_ERR
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;
   localparam logic [1:0] S_DONE = 2'd3;

   logic [1:0]  state;
   logic        we_q;
   logic [31:0] addr_q;
   logic [3:0]  wstrb_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic        trap_q;
   logic        tmo_hit;
   logic        drain;
   logic        m_valid_int;
   logic        handshake;

`ifdef DMEM_TIMEOUT_EN
   localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] tmo_cnt;
   logic             drain_q;

   // Fires on the cycle whose increment would make the count reach the limit.
   assign tmo_hit = (state == S_REQ || state == S_RESP) &&
                    ((tmo_cnt + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));
   assign drain   = drain_q;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         tmo_cnt <= '0;
         drain_q <= 1'b0;
      end else begin
         if (state == S_REQ || state == S_RESP) begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         end else begin
            tmo_cnt <= '0;
         end
         // An abandoned bus transaction still owes us one response; swallow it.
         if (drain_q && M_RVALID) begin
            drain_q <= 1'b0;
         end else if (tmo_hit && ((state == S_RESP && !M_RVALID) || handshake)) begin
            drain_q <= 1'b1;
         end
      end
   end
`else
   assign tmo_hit = 1'b0;
   assign drain   = 1'b0;
`endif

   assign m_valid_int = (state == S_REQ) && !drain;
   assign handshake   = m_valid_int && M_READY;

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state   <= S_IDLE;
         we_q    <= 1'b0;
         addr_q  <= 32'h0;
         wstrb_q <= 4'h0;
         wdata_q <= 32'h0;
         rdata_q <= 32'h0;
         trap_q  <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (REQ_VALID) begin
                  we_q    <= REQ_WE;
                  addr_q  <= REQ_ADDR & 32'hFFFF_FFFC;
                  wstrb_q <= REQ_WE ? REQ_WMASK : 4'h0;
                  wdata_q <= REQ_WDATA;
                  rdata_q <= 32'h0;
                  trap_q  <= 1'b0;
                  // A store with no enabled lanes completes without touching the bus.
                  state   <= (REQ_WE && REQ_WMASK == 4'h0) ? S_DONE : S_REQ;
               end
            end
            S_REQ: begin
               if (tmo_hit) begin
                  trap_q <= 1'b1;
                  state  <= S_DONE;
               end else if (handshake) begin
                  state <= S_RESP;
               end
            end
            S_RESP: begin
               if (M_RVALID) begin
                  rdata_q <= (!we_q && !M_ERR) ? M_RDATA : 32'h0;
                  trap_q  <= M_ERR;
                  state   <= S_DONE;
               end else if (tmo_hit) begin
                  trap_q <= 1'b1;
                  state  <= S_DONE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   // Outputs are forced low while reset is asserted, before the reset edge lands.
   assign STALL       = RST_N && ((state == S_REQ) || (state == S_RESP) ||
                                  ((state == S_IDLE) && REQ_VALID));
   assign RSP_VALID   = RST_N && (state == S_DONE);
   assign RSP_RDATA   = RSP_VALID ? rdata_q : 32'h0;
   assign TRAP_VALID  = RSP_VALID && trap_q;
   assign TRAP_MCAUSE = TRAP_VALID ? (we_q ? 31'd7 : 31'd5) : 31'd0;
   assign M_VALID     = RST_N && m_valid_int;
   assign M_WE        = RST_N && we_q;
   assign M_ADDR      = RST_N ? addr_q  : 32'h0;
   assign M_WSTRB     = RST_N ? wstrb_q : 4'h0;
   assign M_WDATA     = RST_N ? wdata_q : 32'h0;

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning cycles in REQ+RESP before a timeout fault (only used with DMEM_TIMEOUT_EN).
REQ-002 SHALL have ports, in this order:
- CLK  in  1  clock; all logic on its rising edge.
- RST_N  in  1  reset; synchronous, active-low.
- REQ_VALID  in  1  MEM-stage access request.
- REQ_WE  in  1  1 = store, 0 = load.
- REQ_ADDR  in  32  byte address.
- REQ_WMASK  in  4  byte-lane write mask, already formatted.
- REQ_WDATA  in  32  store data, already lane-shifted.
- STALL  out  1  hold the pipeline.
- RSP_VALID  out  1  access complete; one-cycle pulse.
- RSP_RDATA  out  32  raw load word.
- TRAP_VALID  out  1  access fault.
- TRAP_MCAUSE  out  31  fault cause.
- M_VALID  out  1  bus request.
- M_READY  in  1  bus accepts request.
- M_WE  out  1  bus write.
- M_ADDR  out  32  word-aligned address.
- M_WSTRB  out  4  bus byte strobes.
- M_WDATA  out  32  bus write data.
- M_RVALID  in  1  bus response.
- M_RDATA  in  32  bus read data.
- M_ERR  in  1  bus error; qualified by M_RVALID.

Function
REQ-003 SHALL implement FSM IDLE, REQ, RESP, DONE; reset state IDLE.
REQ-004 IDLE with REQ_VALID=1 SHALL capture WE, ADDR with bits [1:0] forced to 0, WMASK and WDATA into registers.
- Store with REQ_WMASK=4'h0: next state DONE; no bus transaction; no trap.
- Otherwise: next state REQ.
REQ-005 REQ SHALL drive M_VALID=1 with the captured M_WE/M_ADDR/M_WSTRB/M_WDATA held stable.
- Advance to RESP on the cycle M_READY=1.
- M_WSTRB SHALL be 4'h0 for loads.
REQ-006 M_RVALID SHALL be ignored outside RESP. The response arrives no earlier than the cycle after the M_READY handshake.
REQ-007 RESP with M_RVALID=1 SHALL register M_RDATA into RSP_RDATA (loads only; 0 for stores) and go to DONE.
REQ-008 DONE SHALL last exactly one cycle with RSP_VALID=1 and STALL=0, then go to IDLE.
REQ-009 STALL SHALL be 1 in REQ and RESP, 1 in IDLE when REQ_VALID=1, and 0 otherwise.
REQ-010 M_RVALID with M_ERR=1 SHALL, in DONE:
- assert TRAP_VALID=1;
- set TRAP_MCAUSE=5 for a load, 7 for a store;
- set RSP_RDATA=0.
REQ-011 TRAP_VALID and TRAP_MCAUSE SHALL be 0 in every state other than a faulting DONE.
REQ-012 Minimum latency SHALL be 4 cycles from request acceptance to RSP_VALID: accept in IDLE, REQ with M_READY, RESP with M_RVALID, DONE.
REQ-013 At most one outstanding bus transaction SHALL exist, and no new request SHALL be accepted before DONE completes.

Reset
REQ-014 RST_N=0 at a clock edge SHALL force IDLE and clear all registers, mid-transaction included.
REQ-015 During and after reset, every output SHALL be 0 until a new request is accepted; any in-flight bus response SHALL be dropped.

Configuration
REQ-016 Macro DMEM_TIMEOUT_EN SHALL compile in a timeout watchdog.
- Counter is cleared on entering REQ and increments each cycle in REQ/RESP.
- When the count reaches TIMEOUT_CYCLES: go to DONE with TRAP_VALID=1, mcause 5 (load) / 7 (store).
- Timeout in RESP SHALL set a drain flag. While the flag is set, M_VALID SHALL stay 0 (FSM holds in REQ). The next M_RVALID is discarded and clears the flag.
- Without the macro: no counter, no drain flag, and REQ/RESP wait indefinitely.

Verification
REQ-017 Load 0x1000_0004, M_READY and M_RVALID immediate, M_RDATA=0xDEADBEEF -> M_ADDR=0x1000_0004, M_WE=0; RSP_VALID pulse on 4th cycle with RSP_RDATA=0xDEADBEEF; STALL high cycles 1-3.
REQ-018 Store addr 0x2003, WMASK=4'h8, WDATA=0xAB00_0000, M_READY delayed 3 cycles -> M_VALID held 4 cycles; M_ADDR=0x2000, M_WSTRB=4'h8; RSP_VALID after M_RVALID.
REQ-019 Store with WMASK=4'h0 -> no M_VALID; RSP_VALID on the cycle after acceptance; TRAP_VALID=0.
REQ-020 Load response with M_ERR=1 -> TRAP_VALID=1, TRAP_MCAUSE=5, RSP_RDATA=0; same for store -> TRAP_MCAUSE=7.
REQ-021 RST_N=0 while in RESP, then M_RVALID the cycle after reset release -> FSM in IDLE; no RSP_VALID; all outputs 0.
REQ-022 With DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=8, M_RVALID withheld -> TRAP_VALID on the 9th cycle after entering REQ; the next request's M_VALID is blocked until the stale M_RVALID arrives.
